// File: rtl/m_st7789_rx_if.sv
// rtl/m_st7789_rx_if.sv - pixel/command write bus produced by the ST7789 receiver
interface m_st7789_rx_if;
    logic [15:0] w_waddr;
    logic [15:0] w_wdata;
    logic        w_we;
    logic [7:0]  w_cmd;
    logic        w_cmd_we;
    logic        w_frame_done;

    modport master (
        output w_waddr, w_wdata, w_we, w_cmd, w_cmd_we, w_frame_done
    );

    modport slave (
        input w_waddr, w_wdata, w_we, w_cmd, w_cmd_we, w_frame_done
    );
endinterface

// File: rtl/m_st7789_rx.sv
// rtl/m_st7789_rx.sv - ST7789 3-wire SPI receiver decoding CASET/RASET/RAMWR into video-memory writes (option: ST7789_RX_SYNC_EN)
module m_st7789_rx #(
    parameter int IDLE_CYC = 64,
    parameter int MAX_X    = 239,
    parameter int MAX_Y    = 239
) (
    input  logic          w_clk,
    input  logic          w_rst_n,
    input  logic          st7789_SDA,
    input  logic          st7789_SCL,
    input  logic          st7789_DC,
    m_st7789_rx_if.master bus
);

    localparam int          IDLE_W = $clog2(IDLE_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYC);
    localparam logic [7:0]  XE_RST = 8'(MAX_X);
    localparam logic [7:0]  YE_RST = 8'(MAX_Y);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_RA,
        ST_WR,
        ST_SKIP
    } state_t;

    logic scl_in;
    logic sda_in;
    logic dc_in;

`ifdef ST7789_RX_SYNC_EN
    logic [1:0] scl_s;
    logic [1:0] sda_s;
    logic [1:0] dc_s;

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            scl_s <= 2'b11;
            sda_s <= 2'b00;
            dc_s  <= 2'b00;
        end else begin
            scl_s <= {scl_s[0], st7789_SCL};
            sda_s <= {sda_s[0], st7789_SDA};
            dc_s  <= {dc_s[0], st7789_DC};
        end
    end

    assign scl_in = scl_s[1];
    assign sda_in = sda_s[1];
    assign dc_in  = dc_s[1];
`else
    assign scl_in = st7789_SCL;
    assign sda_in = st7789_SDA;
    assign dc_in  = st7789_DC;
`endif

    // SCL flops reset high so an idle-high line after reset is not seen as an edge.
    logic scl_r;
    logic scl_p;
    logic sda_r;
    logic dc_r;
    logic rise;

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            scl_r <= 1'b1;
            scl_p <= 1'b1;
            sda_r <= 1'b0;
            dc_r  <= 1'b0;
        end else begin
            scl_r <= scl_in;
            scl_p <= scl_r;
            sda_r <= sda_in;
            dc_r  <= dc_in;
        end
    end

    assign rise = scl_r & ~scl_p;

    logic [7:0]        sr;
    logic [2:0]        bit_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              byte_stb;
    logic [7:0]        byte_q;
    logic              dc_q;

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            sr       <= 8'h00;
            bit_cnt  <= 3'd0;
            idle_cnt <= '0;
            byte_stb <= 1'b0;
            byte_q   <= 8'h00;
            dc_q     <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            if (!scl_r) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (rise) begin
                sr      <= {sr[6:0], sda_r};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_q   <= {sr[6:0], sda_r};
                    dc_q     <= dc_r;
                    byte_stb <= 1'b1;
                end
            end else if (idle_cnt == IDLE_MAX && bit_cnt != 3'd0) begin
                // Long SCL-high gap mid-byte: drop the partial byte and realign.
                bit_cnt <= 3'd0;
            end
        end
    end

    state_t state;
    state_t state_d;

    logic [1:0]  p_idx;
    logic [7:0]  p_lo;
    logic        half;
    logic [7:0]  hi;
    logic [7:0]  xs;
    logic [7:0]  xe;
    logic [7:0]  ys;
    logic [7:0]  ye;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        cmd_stb;
    logic        dat_stb;
    logic        x_end;
    logic        y_end;

    logic [15:0] waddr_q;
    logic [15:0] wdata_q;
    logic        we_q;
    logic [7:0]  cmd_q;
    logic        cmd_we_q;
    logic        fd_q;

    always_comb begin
        state_d = state;
        cmd_stb = byte_stb & ~dc_q;
        dat_stb = byte_stb & dc_q;
        x_end   = (x == xe);
        y_end   = (y == ye);
        if (cmd_stb) begin
            case (byte_q)
                8'h2A:   state_d = ST_CA;
                8'h2B:   state_d = ST_RA;
                8'h2C:   state_d = ST_WR;
                8'h01:   state_d = ST_IDLE;
                default: state_d = ST_SKIP;
            endcase
        end else if (dat_stb && (state == ST_CA || state == ST_RA) && p_idx == 2'd3) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state    <= ST_IDLE;
            p_idx    <= 2'd0;
            p_lo     <= 8'h00;
            half     <= 1'b0;
            hi       <= 8'h00;
            xs       <= 8'h00;
            xe       <= XE_RST;
            ys       <= 8'h00;
            ye       <= YE_RST;
            x        <= 8'h00;
            y        <= 8'h00;
            waddr_q  <= 16'h0000;
            wdata_q  <= 16'h0000;
            we_q     <= 1'b0;
            cmd_q    <= 8'h00;
            cmd_we_q <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            state    <= state_d;
            we_q     <= 1'b0;
            cmd_we_q <= 1'b0;
            fd_q     <= 1'b0;
            if (cmd_stb) begin
                cmd_q    <= byte_q;
                cmd_we_q <= 1'b1;
                p_idx    <= 2'd0;
                half     <= 1'b0;
                if (byte_q == 8'h2C) begin
                    x <= xs;
                    y <= ys;
                end
                if (byte_q == 8'h01) begin
                    xs <= 8'h00;
                    xe <= XE_RST;
                    ys <= 8'h00;
                    ye <= YE_RST;
                end
            end else if (dat_stb) begin
                case (state)
                    ST_CA, ST_RA: begin
                        // Only the low byte of each 16-bit coordinate is kept.
                        p_idx <= p_idx + 2'd1;
                        if (p_idx == 2'd1) begin
                            p_lo <= byte_q;
                        end
                        if (p_idx == 2'd3) begin
                            if (state == ST_CA) begin
                                xs <= p_lo;
                                xe <= byte_q;
                            end else begin
                                ys <= p_lo;
                                ye <= byte_q;
                            end
                        end
                    end
                    ST_WR: begin
                        if (!half) begin
                            hi   <= byte_q;
                            half <= 1'b1;
                        end else begin
                            half    <= 1'b0;
                            wdata_q <= {hi, byte_q};
                            waddr_q <= {y, x};
                            we_q    <= 1'b1;
                            fd_q    <= x_end & y_end;
                            x       <= x_end ? xs : x + 8'd1;
                            if (x_end) begin
                                y <= y_end ? ys : y + 8'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.w_waddr      = waddr_q;
    assign bus.w_wdata      = wdata_q;
    assign bus.w_we         = we_q;
    assign bus.w_cmd        = cmd_q;
    assign bus.w_cmd_we     = cmd_we_q;
    assign bus.w_frame_done = fd_q;

endmodule

// File: tb/tb_m_st7789_rx.sv
// tb/tb_m_st7789_rx.sv - directed self-checking bench for m_st7789_rx
module tb_m_st7789_rx;

`ifdef ST7789_RX_SYNC_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic w_clk      = 1'b0;
    logic w_rst_n    = 1'b0;
    logic st7789_SDA = 1'b0;
    logic st7789_SCL = 1'b1;
    logic st7789_DC  = 1'b0;

    m_st7789_rx_if bus ();

    m_st7789_rx dut (
        .w_clk      (w_clk),
        .w_rst_n    (w_rst_n),
        .st7789_SDA (st7789_SDA),
        .st7789_SCL (st7789_SCL),
        .st7789_DC  (st7789_DC),
        .bus        (bus)
    );

    always #5 w_clk = ~w_clk;

    int checks     = 0;
    int failures   = 0;
    int n_we       = 0;
    int n_cmd      = 0;
    int n_ovl      = 0;
    int n_fd_alone = 0;
    int lat        = 0;

    logic [15:0] log_addr[$];
    logic [15:0] log_data[$];
    logic        log_fd[$];

    logic [15:0] exp_2x2 [4] = '{16'h0A05, 16'h0A06, 16'h0B05, 16'h0B06};
    logic [15:0] exp_wrap[4] = '{16'hEFFE, 16'hEFFF, 16'hEF00, 16'hEF01};

    always @(negedge w_clk) begin
        if (bus.w_we === 1'b1) begin
            n_we++;
            log_addr.push_back(bus.w_waddr);
            log_data.push_back(bus.w_wdata);
            log_fd.push_back(bus.w_frame_done);
        end
        if (bus.w_cmd_we === 1'b1) n_cmd++;
        if (bus.w_we === 1'b1 && bus.w_cmd_we === 1'b1) n_ovl++;
        if (bus.w_frame_done === 1'b1 && bus.w_we !== 1'b1) n_fd_alone++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends the n most significant bits of b; lat records strobe latency of a full byte.
    task automatic send_bits(input logic [7:0] b, input logic dc, input int n);
        lat = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge w_clk);
            st7789_SCL = 1'b0;
            st7789_SDA = b[3'(7 - i)];
            st7789_DC  = dc;
            @(negedge w_clk);
            @(negedge w_clk);
            st7789_SCL = 1'b1;
            if (i == 7) begin
                for (int c = 1; c <= 8; c++) begin
                    @(negedge w_clk);
                    if (lat == 0 && (bus.w_we === 1'b1 || bus.w_cmd_we === 1'b1)) lat = c;
                end
            end else begin
                @(negedge w_clk);
            end
        end
    endtask

    task automatic send_pix(input logic [15:0] p);
        send_bits(p[15:8], 1'b1, 8);
        send_bits(p[7:0], 1'b1, 8);
    endtask

    task automatic send_win(input logic [7:0] c, input logic [7:0] s, input logic [7:0] e);
        send_bits(c, 1'b0, 8);
        send_bits(8'h00, 1'b1, 8);
        send_bits(s, 1'b1, 8);
        send_bits(8'h00, 1'b1, 8);
        send_bits(e, 1'b1, 8);
    endtask

    initial begin
        int base;
        int cbase;

        // Reset held with SCL toggling
        for (int i = 0; i < 40; i++) begin
            @(negedge w_clk);
            st7789_SCL = ~st7789_SCL;
            st7789_SDA = 1'($urandom);
            st7789_DC  = 1'($urandom);
        end
        st7789_SCL = 1'b1;
        repeat (2) @(negedge w_clk);
        check("rst_waddr", 32'(bus.w_waddr), 32'h0);
        check("rst_wdata", 32'(bus.w_wdata), 32'h0);
        check("rst_we", 32'(bus.w_we), 32'h0);
        check("rst_cmd", 32'(bus.w_cmd), 32'h0);
        check("rst_cmd_we", 32'(bus.w_cmd_we), 32'h0);
        check("rst_fd", 32'(bus.w_frame_done), 32'h0);
        check("rst_n_we", 32'(n_we), 32'h0);
        check("rst_n_cmd", 32'(n_cmd), 32'h0);
        w_rst_n = 1'b1;
        repeat (4) @(negedge w_clk);

        // RAMWR with default window
        send_bits(8'h2C, 1'b0, 8);
        check("ramwr_cmd", 32'(bus.w_cmd), 32'h2C);
        check("ramwr_cmd_lat", 32'(lat), 32'(LAT));
        check("ramwr_n_cmd", 32'(n_cmd), 32'd1);
        base = log_addr.size();
        send_pix(16'h1234);
        check("pix0_lat", 32'(lat), 32'(LAT));
        check("pix0_n_we", 32'(n_we), 32'd1);
        check("pix0_addr", 32'(log_addr[base]), 32'h0000);
        check("pix0_data", 32'(log_data[base]), 32'h1234);
        check("pix0_fd", 32'(log_fd[base]), 32'h0);

        // 2x2 window at (5..6, 10..11)
        send_win(8'h2A, 8'h05, 8'h06);
        send_win(8'h2B, 8'h0A, 8'h0B);
        send_bits(8'h2C, 1'b0, 8);
        base = log_addr.size();
        for (int k = 0; k < 5; k++) send_pix({8'hA0 + 8'(k), 8'h50 + 8'(k)});
        check("win_count", 32'(log_addr.size() - base), 32'd5);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("win_addr%0d", k), 32'(log_addr[base + k]), 32'(exp_2x2[k]));
            check($sformatf("win_data%0d", k), 32'(log_data[base + k]), 32'({8'hA0 + 8'(k), 8'h50 + 8'(k)}));
            check($sformatf("win_fd%0d", k), 32'(log_fd[base + k]), (k == 3) ? 32'h1 : 32'h0);
        end
        check("win_restart_addr", 32'(log_addr[base + 4]), 32'h0A05);
        check("win_restart_fd", 32'(log_fd[base + 4]), 32'h0);

        // xs > xe: column counter wraps through 255
        send_win(8'h2A, 8'hFE, 8'h01);
        send_win(8'h2B, 8'hEF, 8'hEF);
        send_bits(8'h2C, 1'b0, 8);
        base = log_addr.size();
        for (int k = 0; k < 4; k++) send_pix(16'h0F00 + 16'(k));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wrap_addr%0d", k), 32'(log_addr[base + k]), 32'(exp_wrap[k]));
            check($sformatf("wrap_fd%0d", k), 32'(log_fd[base + k]), (k == 3) ? 32'h1 : 32'h0);
        end

        // Last pixel of a 240x240 frame
        send_win(8'h2A, 8'hEF, 8'hEF);
        send_bits(8'h2C, 1'b0, 8);
        base = log_addr.size();
        send_pix(16'hF81F);
        check("corner_addr", 32'(log_addr[base]), 32'hEFEF);
        check("corner_fd", 32'(log_fd[base]), 32'h1);

        // Abort mid-pixel
        send_bits(8'h2C, 1'b0, 8);
        send_bits(8'hAA, 1'b1, 8);
        base  = n_we;
        cbase = n_cmd;
        send_bits(8'h29, 1'b0, 8);
        check("abort_cmd", 32'(bus.w_cmd), 32'h29);
        check("abort_n_cmd", 32'(n_cmd - cbase), 32'd1);
        send_bits(8'h55, 1'b1, 8);
        send_bits(8'h66, 1'b1, 8);
        check("abort_no_we", 32'(n_we - base), 32'd0);

        // Partial byte then resync
        base  = n_we;
        cbase = n_cmd;
        send_bits(8'hFF, 1'b0, 3);
        repeat (64) @(negedge w_clk);
        check("partial_no_strobe", 32'(n_cmd - cbase), 32'd0);
        send_bits(8'h2C, 1'b0, 8);
        check("partial_cmd", 32'(bus.w_cmd), 32'h2C);
        check("partial_n_cmd", 32'(n_cmd - cbase), 32'd1);
        check("partial_no_we", 32'(n_we - base), 32'd0);

        // Software reset restores full window
        send_bits(8'h01, 1'b0, 8);
        send_bits(8'h2C, 1'b0, 8);
        base = log_addr.size();
        send_pix(16'h0001);
        send_pix(16'h0002);
        check("swrst_addr0", 32'(log_addr[base]), 32'h0000);
        check("swrst_addr1", 32'(log_addr[base + 1]), 32'h0001);
        check("swrst_fd1", 32'(log_fd[base + 1]), 32'h0);

        // Reset pulsed after 5 bits
        send_bits(8'h2B, 1'b0, 5);
        @(negedge w_clk);
        w_rst_n = 1'b0;
        @(negedge w_clk);
        w_rst_n = 1'b1;
        @(negedge w_clk);
        check("midrst_cmd_cleared", 32'(bus.w_cmd), 32'h0);
        send_bits(8'h2C, 1'b0, 8);
        check("midrst_cmd", 32'(bus.w_cmd), 32'h2C);
        base = log_addr.size();
        send_pix(16'hBEEF);
        check("midrst_addr", 32'(log_addr[base]), 32'h0000);
        check("midrst_data", 32'(log_data[base]), 32'hBEEF);

        check("no_overlap", 32'(n_ovl), 32'd0);
        check("no_lone_fd", 32'(n_fd_alone), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
